// File: rtl/sparc_mem_responder_if.sv
// Processor <-> memory handshake bundle: request (mov/r_w/type), MAR/MDR data paths,
// and the completion/error responses returned to the control unit.
interface sparc_mem_responder_if;
    logic        mov;
    logic        r_w;
    logic [1:0]  op_type;   // 00 byte, 01 halfword, 10 word, 11 reserved
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        moc;
    logic        mae;

    modport master (
        output mov, r_w, op_type, addr, data_in,
        input  data_out, moc, mae
    );

    modport slave (
        input  mov, r_w, op_type, addr, data_in,
        output data_out, moc, mae
    );
endinterface

// File: rtl/sparc_mem_responder.sv
// Memory-side responder for the four-phase mov/moc handshake: byte-addressed big-endian RAM
// serving byte/halfword/word accesses with alignment checking and programmable wait states.
module sparc_mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Clr,
    sparc_mem_responder_if.slave  bus
);
    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                r_w_q, r_w_d;
    logic [1:0]          type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_out_q, data_out_d;
    logic                mae_q, mae_d;
    logic                moc_q, moc_d;

    logic [7:0]          mem [DEPTH];

    logic                acc_r_w;
    logic [1:0]          acc_type;
    logic [ADDR_W-1:0]   a0, a1, a2, a3;
    logic [31:0]         acc_wdata;
    logic                misaligned;
    logic                done_entry;
    logic                wr_en;
    logic [31:0]         rd_data;
    logic                addr_hi_unused;

    assign addr_hi_unused = ^bus.addr[31:ADDR_W];

    // With zero wait states DONE is entered straight from IDLE, before the request
    // registers hold anything, so the access uses the live bus values in that case.
    always_comb begin
        acc_r_w   = (state_q == IDLE) ? bus.r_w               : r_w_q;
        acc_type  = (state_q == IDLE) ? bus.op_type           : type_q;
        a0        = (state_q == IDLE) ? bus.addr[ADDR_W-1:0]  : addr_q;
        acc_wdata = (state_q == IDLE) ? bus.data_in           : wdata_q;
        a1        = a0 + ADDR_W'(1);
        a2        = a0 + ADDR_W'(2);
        a3        = a0 + ADDR_W'(3);
    end

    always_comb begin
        misaligned = 1'b0;
        case (acc_type)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a0[0];
            2'b10:   misaligned = |a0[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Big-endian: the lowest address holds the most significant byte.
    always_comb begin
        rd_data = 32'd0;
        case (acc_type)
            2'b00:   rd_data = {24'd0, mem[a0]};
            2'b01:   rd_data = {16'd0, mem[a0], mem[a1]};
            default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_w_d      = r_w_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        mae_d      = mae_q;
        moc_d      = (state_q == DONE);
        done_entry = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.mov) begin
                    r_w_d   = bus.r_w;
                    type_d  = bus.op_type;
                    addr_d  = bus.addr[ADDR_W-1:0];
                    wdata_d = bus.data_in;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (!bus.mov) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.mov) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                mae_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The access commits on the single edge that enters DONE.
        done_entry = (state_d == DONE) && (state_q != DONE);
        if (done_entry) begin
            mae_d = misaligned;
            if (!misaligned && acc_r_w) begin
                data_out_d = rd_data;
            end
            wr_en = !misaligned && !acc_r_w;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            data_out_q <= 32'd0;
            mae_q      <= 1'b0;
            moc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            mae_q      <= mae_d;
            moc_q      <= moc_d;
        end
        r_w_q   <= r_w_d;
        type_q  <= type_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // RAM contents survive Clr; only an uncommitted write is dropped by it.
    always_ff @(posedge Clk) begin
        if (!Clr && wr_en) begin
            case (acc_type)
                2'b00: begin
                    mem[a0] <= acc_wdata[7:0];
                end
                2'b01: begin
                    mem[a0] <= acc_wdata[15:8];
                    mem[a1] <= acc_wdata[7:0];
                end
                default: begin
                    mem[a0] <= acc_wdata[31:24];
                    mem[a1] <= acc_wdata[23:16];
                    mem[a2] <= acc_wdata[15:8];
                    mem[a3] <= acc_wdata[7:0];
                end
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.mae      = mae_q;
    assign bus.moc      = moc_q;
endmodule

// File: tb/tb_sparc_mem_responder.sv
// Directed bench for sparc_mem_responder: two instances (2 wait states, 0 wait states)
// driven through a vector table plus hand sequences for handshake hold and mid-transaction reset.
module tb_sparc_mem_responder;
    logic Clk = 1'b0;
    logic Clr;
    always #5 Clk = ~Clk;

    sparc_mem_responder_if b0 ();
    sparc_mem_responder_if b1 ();

    sparc_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) dut0 (.Clk(Clk), .Clr(Clr), .bus(b0.slave));
    sparc_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut1 (.Clk(Clk), .Clr(Clr), .bus(b1.slave));

    typedef struct {
        int          sel;
        logic        r_w;
        logic [1:0]  t;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_mae;
        logic [31:0] exp_dout;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic mov, input logic r_w, input logic [1:0] t,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            b0.mov = mov; b0.r_w = r_w; b0.op_type = t; b0.addr = a; b0.data_in = d;
        end else begin
            b1.mov = mov; b1.r_w = r_w; b1.op_type = t; b1.addr = a; b1.data_in = d;
        end
    endtask

    task automatic set_mov(input int sel, input logic v);
        if (sel == 0) b0.mov = v;
        else          b1.mov = v;
    endtask

    task automatic sample(input int sel, output logic moc, output logic mae, output logic [31:0] dout);
        if (sel == 0) begin
            moc = b0.moc; mae = b0.mae; dout = b0.data_out;
        end else begin
            moc = b1.moc; mae = b1.mae; dout = b1.data_out;
        end
    endtask

    // Waits (bounded) for moc; lat counts negedges after the edge that sampled mov.
    task automatic wait_moc(input int sel, output int lat, output logic mae, output logic [31:0] dout);
        logic moc;
        lat = -1;
        mae = 1'b0;
        dout = 32'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            sample(sel, moc, mae, dout);
            if (moc) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_txn(input int sel, input logic r_w, input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] d, output int lat, output logic mae,
                           output logic [31:0] dout, output logic moc_hold, output logic moc_fall);
        logic m1, m2;
        logic [31:0] dd;
        @(negedge Clk);
        drive(sel, 1'b1, r_w, t, a, d);
        wait_moc(sel, lat, mae, dout);
        set_mov(sel, 1'b0);
        @(negedge Clk);
        sample(sel, moc_hold, m1, dd);
        @(negedge Clk);
        sample(sel, moc_fall, m2, dd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        mae, moc, moc_hold, moc_fall, moc_any;
        logic [31:0] dout;

        vecs[0]  = '{0, 1'b0, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{0, 1'b1, 2'b00, 32'h0000_0011, 32'h0,         1'b0, 32'h0000_00AD};
        vecs[2]  = '{0, 1'b1, 2'b01, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_BEEF};
        vecs[3]  = '{0, 1'b0, 2'b00, 32'h0000_0013, 32'h0000_0055, 1'b0, 32'h0000_BEEF};
        vecs[4]  = '{0, 1'b1, 2'b10, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BE55};
        vecs[5]  = '{0, 1'b1, 2'b10, 32'h0000_000E, 32'h0,         1'b1, 32'hDEAD_BE55};
        vecs[6]  = '{0, 1'b0, 2'b10, 32'h0000_0020, 32'h0102_0304, 1'b0, 32'hDEAD_BE55};
        vecs[7]  = '{0, 1'b0, 2'b01, 32'h0000_0021, 32'h0000_1234, 1'b1, 32'hDEAD_BE55};
        vecs[8]  = '{0, 1'b1, 2'b10, 32'h0000_0020, 32'h0,         1'b0, 32'h0102_0304};
        vecs[9]  = '{0, 1'b1, 2'b11, 32'h0000_0020, 32'h0,         1'b1, 32'h0102_0304};
        vecs[10] = '{0, 1'b0, 2'b11, 32'h0000_0030, 32'hFFFF_FFFF, 1'b1, 32'h0102_0304};
        vecs[11] = '{0, 1'b0, 2'b10, 32'h0000_0040, 32'h1122_3344, 1'b0, 32'h0102_0304};
        vecs[12] = '{0, 1'b1, 2'b01, 32'h0000_0042, 32'h0,         1'b0, 32'h0000_3344};
        vecs[13] = '{1, 1'b0, 2'b00, 32'h0000_0205, 32'h0000_00A5, 1'b0, 32'h0000_0000};
        vecs[14] = '{1, 1'b1, 2'b00, 32'h0000_0005, 32'h0,         1'b0, 32'h0000_00A5};
        vecs[15] = '{1, 1'b1, 2'b01, 32'h0000_0205, 32'h0,         1'b1, 32'h0000_00A5};
        vecs[16] = '{1, 1'b0, 2'b10, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0, 32'h0000_00A5};
        vecs[17] = '{1, 1'b1, 2'b10, 32'h0000_01FC, 32'h0,         1'b0, 32'h0BAD_F00D};

        Clr = 1'b1;
        drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Clr = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sample(s, moc, mae, dout);
            check($sformatf("rst%0d_moc", s), {31'd0, moc}, 32'd0);
            check($sformatf("rst%0d_mae", s), {31'd0, mae}, 32'd0);
            check($sformatf("rst%0d_dout", s), dout, 32'd0);
        end

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i].sel, vecs[i].r_w, vecs[i].t, vecs[i].addr, vecs[i].wdata,
                    lat, mae, dout, moc_hold, moc_fall);
            check($sformatf("v%0d_lat", i), lat, (vecs[i].sel == 0) ? 32'd3 : 32'd1);
            check($sformatf("v%0d_mae", i), {31'd0, mae}, {31'd0, vecs[i].exp_mae});
            check($sformatf("v%0d_dout", i), dout, vecs[i].exp_dout);
            check($sformatf("v%0d_moc_hold", i), {31'd0, moc_hold}, 32'd1);
            check($sformatf("v%0d_moc_fall", i), {31'd0, moc_fall}, 32'd0);
        end

        // Handshake hold: mov held 5 cycles past moc, then re-asserted while in RELEASE.
        @(negedge Clk);
        drive(0, 1'b1, 1'b1, 2'b10, 32'h0000_0010, 32'h0);
        wait_moc(0, lat, mae, dout);
        check("hold_lat", lat, 32'd3);
        check("hold_dout", dout, 32'hDEAD_BE55);
        moc_any = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            sample(0, moc, mae, dout);
            moc_any = moc_any & moc;
        end
        check("hold_moc_steady", {31'd0, moc_any}, 32'd1);
        set_mov(0, 1'b0);
        @(negedge Clk);
        sample(0, moc, mae, dout);
        check("hold_moc_release_edge", {31'd0, moc}, 32'd1);
        set_mov(0, 1'b1);
        @(negedge Clk);
        sample(0, moc, mae, dout);
        check("hold_moc_low", {31'd0, moc}, 32'd0);
        wait_moc(0, lat, mae, dout);
        check("b2b_deferred_lat", lat, 32'd3);
        check("b2b_dout", dout, 32'hDEAD_BE55);
        set_mov(0, 1'b0);
        repeat (2) @(negedge Clk);

        // Reset during WAIT of a word write to 0x40, with mov still high on the reset edge.
        @(negedge Clk);
        drive(0, 1'b1, 1'b0, 2'b10, 32'h0000_0040, 32'hCAFE_F00D);
        @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        set_mov(0, 1'b0);
        moc_any = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            sample(0, moc, mae, dout);
            moc_any = moc_any | moc;
        end
        check("rstmid_moc", {31'd0, moc_any}, 32'd0);
        check("rstmid_mae", {31'd0, mae}, 32'd0);
        check("rstmid_dout", dout, 32'd0);
        run_txn(0, 1'b1, 2'b10, 32'h0000_0040, 32'h0, lat, mae, dout, moc_hold, moc_fall);
        check("rstmid_read_lat", lat, 32'd3);
        check("rstmid_read_mae", {31'd0, mae}, 32'd0);
        check("rstmid_read_dout", dout, 32'h1122_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sparc_mem_responder.md
# sparc_mem_responder

Memory-side responder for the processor's memory handshake (mov / r_w / type / moc). Holds a byte-addressed, big-endian RAM and services one byte, halfword or word access at a time. Holds the memory-operation-complete signal until the processor drops its request. Sits opposite the datapath's MAR/MDR port and returns MOC to the control unit.

## Interface
- ADDR_W, 9: byte-address bits decoded (memory depth = 2^ADDR_W bytes).
- WAIT_CYCLES, 2: wait states between request acceptance and moc; range 0–15.
- Clk  in  1  system clock; all state changes on rising edge.
- Clr  in  1  reset, synchronous and active-high.
- mov  in  1  memory operation valid (request), level-held by the processor until moc seen.
- r_w  in  1  1 = read, 0 = write; sampled with mov.
- type  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- addr  in  32  byte address (from MAR); only addr[ADDR_W-1:0] decoded.
- data_in  in  32  write data, right-justified (from MDR).
- data_out  out  32  read data, right-justified, zero-extended.
- moc  out  1  memory operation complete.
- mae  out  1  memory address error; valid while moc = 1.

## Operation
- FSM states: IDLE, WAIT, DONE, RELEASE.
- IDLE: when mov = 1, latch r_w, type, addr[ADDR_W-1:0] and data_in, and clear the wait counter.
  - WAIT_CYCLES = 0: go to DONE.
  - Otherwise: go to WAIT.
- WAIT: increment the counter. After WAIT_CYCLES cycles in WAIT, go to DONE. mov dropping during WAIT aborts: go to IDLE, no write, moc never asserted.
- Entry to DONE (the single edge that enters DONE) does all of the following:
  - Alignment check. Halfword needs addr[0] = 0. Word needs addr[1:0] = 00. type 11 always fails. Failure sets mae = 1, suppresses the write and leaves data_out unchanged.
  - Write (r_w = 0, aligned): byte stores data_in[7:0] at A. Halfword stores data_in[15:8] at A and [7:0] at A+1. Word stores [31:24] at A, then [23:16], [15:8] and [7:0] at A+1..A+3.
  - Read (r_w = 1, aligned): byte gives {24'b0, M[A]}. Halfword gives {16'b0, M[A], M[A+1]}. Word gives {M[A], M[A+1], M[A+2], M[A+3]}.
  - A write leaves data_out unchanged.
- DONE: moc = 1. Stay while mov = 1. When mov = 0, go to RELEASE.
- RELEASE: moc = 0 and mae = 0, then go to IDLE. A new mov is not accepted in RELEASE, so there is at least one dead cycle between transactions.
- Four-phase handshake. The processor must not change addr, type, r_w or data_in while mov = 1. The responder uses only the values latched in IDLE.
- Address wrap: bits above ADDR_W-1 are ignored. A+k is computed modulo 2^ADDR_W and is only relevant for aligned accesses, which never cross the top.
- Memory contents are not cleared by Clr. They are undefined until written.

## Timing
- Reset values: state IDLE, moc 0, mae 0, data_out 0, counter 0.
- Clr asserted in any state returns to IDLE on that edge. A write not yet committed (state before DONE) is dropped. A write committed at DONE entry remains.
- Clr has priority over every other input.
- Latency: if mov is sampled high at edge N, moc is 1 after edge N+1+WAIT_CYCLES. It stays 1 through the edge where mov is first sampled low, then returns to 0 after the following edge.
- data_out and mae are valid in the same cycle moc first rises. data_out holds until the next successful read or Clr.
- Simultaneous events:
  - mov = 1 and Clr = 1 on the same edge: reset wins, request ignored.
  - mov re-asserted in RELEASE: ignored, then accepted from IDLE on the next edge.

## Test plan
- Write word 0xDEADBEEF to addr 0x10 (WAIT_CYCLES = 2), then byte read at 0x11 and halfword read at 0x12. Expected:
  - The write's moc rises exactly 3 cycles after mov is sampled.
  - Byte read returns 0x000000AD.
  - Halfword read returns 0x0000BEEF.
- Byte write 0x55 to 0x13 over the word above, then word read at 0x10 → 0xDEADBE55.
- Misaligned accesses:
  - Word read at 0x0E: mae = 1 with moc, data_out unchanged.
  - Halfword write 0x1234 at 0x21: mae = 1 and a follow-up word read of 0x20 shows no change.
  - type = 11 at any address: mae = 1.
- Handshake hold: keep mov high 5 cycles after moc rises. moc stays 1 throughout, falls one cycle after mov falls, and a back-to-back mov in RELEASE is deferred one cycle.
- Reset mid-transaction: word write 0xCAFEF00D to 0x40 with Clr pulsed during WAIT. Expected:
  - moc never rises, outputs at reset values.
  - A subsequent read of 0x40 returns the prior contents.
- Upper-address aliasing and zero wait (ADDR_W = 9, WAIT_CYCLES = 0): write 0xA5 to 0x0000_0205, read byte 0x005 → 0x000000A5, and moc rises 1 cycle after mov is sampled.
